// File: rtl/robot_cmd_parser.sv
// Command framer for the UART receive FIFO. It hunts for SYNC and assembles
// SYNC,CMD,LEN,PAYLOAD,CHK. Good frames are strobed out; bad or stalled frames are dropped.
module robot_cmd_parser #(
  parameter int                     DATA_BITS     = 8,
  parameter int                     MAX_PAYLOAD   = 8,
  parameter logic [DATA_BITS-1:0]   SYNC_BYTE     = 8'hAA,
  parameter int                     TIMEOUT_TICKS = 1000,
  parameter int                     TIMEOUT_BITS  = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_empty,
  input  logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_rd,
  output logic                               pkt_valid,
  output logic [DATA_BITS-1:0]               pkt_cmd,
  output logic [3:0]                         pkt_len,
  output logic [MAX_PAYLOAD*DATA_BITS-1:0]   pkt_payload,
  output logic                               pkt_error,
  output logic [1:0]                         err_code,
  output logic                               busy
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK} state_t;

  localparam logic [DATA_BITS-1:0]    MAX_LEN = DATA_BITS'(MAX_PAYLOAD);
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT_TICKS - 1);

  state_t                                  state;
  logic [MAX_PAYLOAD-1:0][DATA_BITS-1:0]   shadow;
  logic [DATA_BITS-1:0]                    cmd_sh;
  logic [DATA_BITS-1:0]                    sum;
  logic [3:0]                              len_sh;
  logic [3:0]                              idx;
  logic [TIMEOUT_BITS-1:0]                 tmr;
  logic                                    pop;

  // The parser never back-pressures the FIFO; every available byte is consumed.
  assign pop   = !rx_empty;
  assign rx_rd = pop;
  assign busy  = (state != HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      shadow      <= '0;
      cmd_sh      <= '0;
      sum         <= '0;
      len_sh      <= '0;
      idx         <= '0;
      tmr         <= '0;
      pkt_valid   <= 1'b0;
      pkt_error   <= 1'b0;
      err_code    <= '0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pkt_payload <= '0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;

      if (state == HUNT || pop) tmr <= '0;
      else                      tmr <= tmr + 1'b1;

      if (pop) begin
        case (state)
          HUNT: if (rx_data == SYNC_BYTE) state <= CMD;
          CMD: begin
            cmd_sh <= rx_data;
            sum    <= rx_data;
            shadow <= '0;
            state  <= LEN;
          end
          LEN: begin
            if (rx_data > MAX_LEN) begin
              pkt_error <= 1'b1;
              err_code  <= 2'b01;
              state     <= HUNT;
            end else begin
              len_sh <= rx_data[3:0];
              sum    <= sum + rx_data;
              idx    <= '0;
              state  <= (rx_data == '0) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            for (int unsigned i = 0; i < MAX_PAYLOAD; i++)
              if (32'(idx) == i) shadow[i] <= rx_data;
            sum <= sum + rx_data;
            idx <= idx + 4'd1;
            if (idx == len_sh - 4'd1) state <= CHK;
          end
          CHK: begin
            if (rx_data == sum) begin
              pkt_valid   <= 1'b1;
              pkt_cmd     <= cmd_sh;
              pkt_len     <= len_sh;
              pkt_payload <= shadow;
            end else begin
              pkt_error <= 1'b1;
              err_code  <= 2'b10;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT && tmr == TO_LAST) begin
        // A pop in the expiry cycle takes the branch above, so it always wins.
        pkt_error <= 1'b1;
        err_code  <= 2'b11;
        state     <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_robot_cmd_parser.sv
// Directed bench for robot_cmd_parser covering good, malformed, timed-out,
// back-to-back and reset-interrupted frames.
module tb_robot_cmd_parser;

  localparam int TICKS = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        pkt_valid;
  logic [7:0]  pkt_cmd;
  logic [3:0]  pkt_len;
  logic [63:0] pkt_payload;
  logic        pkt_error;
  logic [1:0]  err_code;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int cyc      = 0;

  robot_cmd_parser #(
    .DATA_BITS(8), .MAX_PAYLOAD(8), .SYNC_BYTE(8'hAA),
    .TIMEOUT_TICKS(TICKS), .TIMEOUT_BITS(10)
  ) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
    .pkt_payload(pkt_payload), .pkt_error(pkt_error), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_rd) pop_cnt <= pop_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_empty = 1'b0;
    rx_data  = b;
    @(posedge clk); #1;
    rx_empty = 1'b1;
  endtask

  task automatic idle();
    rx_empty = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},   64'(pkt_valid),   64'd0);
    check({tag, "_error"},   64'(pkt_error),   64'd0);
    check({tag, "_errcode"}, 64'(err_code),    64'd0);
    check({tag, "_cmd"},     64'(pkt_cmd),     64'd0);
    check({tag, "_len"},     64'(pkt_len),     64'd0);
    check({tag, "_payload"}, pkt_payload,      64'd0);
    check({tag, "_busy"},    64'(busy),        64'd0);
  endtask

  initial begin
    int t1;
    bit early;
    rst = 1'b1; rx_empty = 1'b1; rx_data = '0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals("reset");
    check("reset_rd", 64'(rx_rd), 64'd0);
    rst = 1'b0;
    idle();

    // Good frame: 10+02+05+07 = 1E
    pop_cnt = 0;
    push(8'hAA);
    check("t1_busy", 64'(busy), 64'd1);
    push(8'h10); push(8'h02); push(8'h05); push(8'h07); push(8'h1E);
    check("t1_valid",   64'(pkt_valid), 64'd1);
    check("t1_cmd",     64'(pkt_cmd),   64'h10);
    check("t1_len",     64'(pkt_len),   64'd2);
    check("t1_payload", pkt_payload,    64'h0705);
    check("t1_pops",    64'(pop_cnt),   64'd6);
    idle();
    check("t1_pulse", 64'(pkt_valid), 64'd0);
    check("t1_idle",  64'(busy),      64'd0);

    // Garbage then zero-length frame: CHK = 33+00 = 33
    push(8'h00); push(8'hFF); push(8'h55);
    check("t2_garbage_busy", 64'(busy),      64'd0);
    check("t2_garbage_err",  64'(pkt_error), 64'd0);
    push(8'hAA); push(8'h33); push(8'h00); push(8'h33);
    check("t2_valid",   64'(pkt_valid), 64'd1);
    check("t2_cmd",     64'(pkt_cmd),   64'h33);
    check("t2_len",     64'(pkt_len),   64'd0);
    check("t2_payload", pkt_payload,    64'd0);
    check("t2_noerr",   64'(pkt_error), 64'd0);
    idle();

    // Length overflow, then checksum mismatch (10+01+05 = 16, not 00)
    push(8'hAA); push(8'h10); push(8'h09);
    check("t3_ovf_err",   64'(pkt_error), 64'd1);
    check("t3_ovf_code",  64'(err_code),  64'd1);
    check("t3_ovf_valid", 64'(pkt_valid), 64'd0);
    check("t3_ovf_busy",  64'(busy),      64'd0);
    push(8'hAA); push(8'h10); push(8'h01); push(8'h05); push(8'h00);
    check("t3_chk_err",   64'(pkt_error), 64'd1);
    check("t3_chk_code",  64'(err_code),  64'd2);
    check("t3_hold_cmd",  64'(pkt_cmd),   64'h33);
    check("t3_hold_len",  64'(pkt_len),   64'd0);
    check("t3_hold_pay",  pkt_payload,    64'd0);
    idle();
    check("t3_err_pulse", 64'(pkt_error), 64'd0);
    check("t3_code_held", 64'(err_code),  64'd2);

    // Timeout: error exactly TICKS cycles after the last pop
    push(8'hAA); push(8'h10); push(8'h02); push(8'h05);
    early = 1'b0;
    for (int i = 0; i < TICKS - 1; i++) begin
      idle();
      if (pkt_error) early = 1'b1;
    end
    check("t4_no_early_err", 64'(early), 64'd0);
    idle();
    check("t4_to_err",  64'(pkt_error), 64'd1);
    check("t4_to_code", 64'(err_code),  64'd3);
    check("t4_to_busy", 64'(busy),      64'd0);
    idle();
    check("t4_to_pulse", 64'(pkt_error), 64'd0);

    // Stall of TICKS-1 cycles: the pop lands on the expiry cycle and wins
    push(8'hAA); push(8'h10); push(8'h02); push(8'h05);
    for (int i = 0; i < TICKS - 1; i++) idle();
    check("t4_stall_busy", 64'(busy),      64'd1);
    check("t4_stall_err",  64'(pkt_error), 64'd0);
    push(8'h07);
    check("t4_pop_wins", 64'(pkt_error), 64'd0);
    push(8'h1E);
    check("t4_valid",   64'(pkt_valid), 64'd1);
    check("t4_cmd",     64'(pkt_cmd),   64'h10);
    check("t4_payload", pkt_payload,    64'h0705);
    idle();

    // Back-to-back: CHK of first frame = (01+01+FF) mod 256 = 01
    push(8'hAA); push(8'h01); push(8'h01); push(8'hFF); push(8'h01);
    t1 = cyc;
    check("t5_valid1",   64'(pkt_valid), 64'd1);
    check("t5_cmd1",     64'(pkt_cmd),   64'h01);
    check("t5_payload1", pkt_payload,    64'hFF);
    push(8'hAA);
    check("t5_sync_busy", 64'(busy), 64'd1);
    push(8'h02); push(8'h00); push(8'h02);
    check("t5_valid2",  64'(pkt_valid), 64'd1);
    check("t5_cmd2",    64'(pkt_cmd),   64'h02);
    check("t5_len2",    64'(pkt_len),   64'd0);
    check("t5_pay2",    pkt_payload,    64'd0);
    check("t5_spacing", 64'(cyc - t1),  64'd4);
    idle();

    // Reset mid-frame
    push(8'hAA); push(8'h10); push(8'h02);
    check("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    push(8'hAA); push(8'h20); push(8'h00); push(8'h20);
    check("t6_valid", 64'(pkt_valid), 64'd1);
    check("t6_cmd",   64'(pkt_cmd),   64'h20);
    check("t6_noerr", 64'(pkt_error), 64'd0);
    check("t6_code",  64'(err_code),  64'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
